// File: rtl/add_slot_scheduler.sv
// add_slot_scheduler: shares one 8-bit adder slice between two requesters, running word adds
// as chained low/high byte passes. Define ADD_SLOT_SCHEDULER_RR_EN for round-robin arbitration.
module add_slot_scheduler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid0,
    input  logic        req_valid1,
    output logic        req_ready0,
    output logic        req_ready1,
    input  logic [15:0] req_a0,
    input  logic [15:0] req_b0,
    input  logic [15:0] req_a1,
    input  logic [15:0] req_b1,
    input  logic        req_word0,
    input  logic        req_word1,
    input  logic        req_ci0,
    input  logic        req_ci1,
    output logic        rsp_valid0,
    output logic        rsp_valid1,
    input  logic        rsp_ready0,
    input  logic        rsp_ready1,
    output logic [15:0] rsp_sum,
    output logic [3:0]  rsp_flags,
    output logic [7:0]  add_a,
    output logic [7:0]  add_b,
    output logic        add_ci,
    input  logic [7:0]  add_r,
    input  logic        add_co
);
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t      state;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        op_word;
    logic        op_ci;
    logic        owner;
    logic        carry;
    logic        any_valid;
    logic        grant1;

    assign any_valid = req_valid0 || req_valid1;

`ifdef ADD_SLOT_SCHEDULER_RR_EN
    logic rr_ptr;  // requester that wins the next tie

    assign grant1 = req_valid1 && (!req_valid0 || rr_ptr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (state == IDLE && any_valid) begin
            rr_ptr <= !grant1;
        end
    end
`else
    assign grant1 = req_valid1 && !req_valid0;
`endif

    // Ready is decoded from IDLE so the grant and operand capture share one edge; it is
    // gated by rst_n so nothing is acknowledged while the block is held in reset.
    assign req_ready0 = rst_n && (state == IDLE) && req_valid0 && !grant1;
    assign req_ready1 = rst_n && (state == IDLE) && grant1;

    assign rsp_valid0 = (state == DONE) && !owner;
    assign rsp_valid1 = (state == DONE) && owner;

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        add_a  = 8'h00;
        add_b  = 8'h00;
        add_ci = 1'b0;
        case (state)
            LO: begin
                add_a  = op_a[7:0];
                add_b  = op_b[7:0];
                add_ci = op_ci;
            end
            HI: begin
                add_a  = op_a[15:8];
                add_b  = op_b[15:8];
                add_ci = carry;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_a      <= 16'h0000;
            op_b      <= 16'h0000;
            op_word   <= 1'b0;
            op_ci     <= 1'b0;
            owner     <= 1'b0;
            carry     <= 1'b0;
            rsp_sum   <= 16'h0000;
            rsp_flags <= 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        owner   <= grant1;
                        op_a    <= grant1 ? req_a1    : req_a0;
                        op_b    <= grant1 ? req_b1    : req_b0;
                        op_word <= grant1 ? req_word1 : req_word0;
                        op_ci   <= grant1 ? req_ci1   : req_ci0;
                        state   <= LO;
                    end
                end
                LO: begin
                    rsp_sum <= {8'h00, add_r};
                    carry   <= add_co;
                    if (op_word) begin
                        state <= HI;
                    end else begin
                        rsp_flags <= {(op_a[7] == op_b[7]) && (add_r[7] != op_a[7]),
                                      add_r[7], add_r == 8'h00, add_co};
                        state     <= DONE;
                    end
                end
                HI: begin
                    rsp_sum[15:8] <= add_r;
                    carry         <= add_co;
                    rsp_flags     <= {(op_a[15] == op_b[15]) && (add_r[7] != op_a[15]),
                                      add_r[7], (add_r == 8'h00) && (rsp_sum[7:0] == 8'h00),
                                      add_co};
                    state         <= DONE;
                end
                DONE: begin
                    if (owner ? rsp_ready1 : rsp_ready0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_add_slot_scheduler.sv
// Scoreboard bench for add_slot_scheduler: a cycle-level reference model predicts grants, adder
// drive and response timing, and a separate monitor checks each response against a queue.
`timescale 1ns/1ps
module tb_add_slot_scheduler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid;
    logic [1:0]  req_word;
    logic [1:0]  req_ci;
    logic [1:0]  rsp_ready;
    logic [15:0] req_a [2];
    logic [15:0] req_b [2];
    logic        req_ready0, req_ready1, rsp_valid0, rsp_valid1;
    logic [15:0] rsp_sum;
    logic [3:0]  rsp_flags;
    logic [7:0]  add_a, add_b, add_r;
    logic        add_ci, add_co;

    always #5 clk = ~clk;

    // Shared adder slice
    assign {add_co, add_r} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_ci};

    add_slot_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid0(req_valid[0]), .req_valid1(req_valid[1]),
        .req_ready0(req_ready0), .req_ready1(req_ready1),
        .req_a0(req_a[0]), .req_b0(req_b[0]), .req_a1(req_a[1]), .req_b1(req_b[1]),
        .req_word0(req_word[0]), .req_word1(req_word[1]),
        .req_ci0(req_ci[0]), .req_ci1(req_ci[1]),
        .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
        .rsp_ready0(rsp_ready[0]), .rsp_ready1(rsp_ready[1]),
        .rsp_sum(rsp_sum), .rsp_flags(rsp_flags),
        .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
        .add_r(add_r), .add_co(add_co)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int          owner;
        logic [15:0] a;
        logic [15:0] b;
        logic        word;
        logic        ci;
        logic        lo_carry;
        logic [15:0] sum;
        logic [3:0]  flags;
        int          acc_win;
    } op_t;

    op_t     q[$];
    op_t     cur;
    bit      busy = 1'b0;
    bit      ptr = 1'b0;
    bit [1:0] acc = 2'b00;
    int      cyc = 0;

    always @(posedge clk) cyc++;

    function automatic op_t make_op(input int n);
        op_t o;
        int unsigned mask, r;
        int w;
        logic am, bm, sm;
        o.owner = n;
        o.a = req_a[n];
        o.b = req_b[n];
        o.word = req_word[n];
        o.ci = req_ci[n];
        mask = o.word ? 32'h0000_FFFF : 32'h0000_00FF;
        w = o.word ? 16 : 8;
        r = (32'(o.a) & mask) + (32'(o.b) & mask) + 32'(o.ci);
        o.sum = 16'(r & mask);
        o.lo_carry = (((32'(o.a) & 32'hFF) + (32'(o.b) & 32'hFF) + 32'(o.ci)) >> 8) != 0;
        am = o.a[w-1];
        bm = o.b[w-1];
        sm = o.sum[w-1];
        o.flags = {(am == bm) && (sm != am), sm, o.sum == 16'h0000, ((r >> w) & 1) != 0};
        o.acc_win = 0;
        return o;
    endfunction

    // Reference model: one op at a time; LO one window after acceptance, HI next for words,
    // response presented from acceptance+2 (byte) / +3 (word) until its owner takes it.
    always @(negedge clk) begin
        logic [1:0] exp_rdy, exp_rv;
        logic [7:0] ea, eb;
        logic       eci;
        int         ph, due, n;
        acc = 2'b00;
        exp_rdy = 2'b00;
        exp_rv = 2'b00;
        ea = 8'h00;
        eb = 8'h00;
        eci = 1'b0;
        if (!rst_n) begin
            busy = 1'b0;
            ptr = 1'b0;
            q.delete();
        end else if (!busy) begin
            if (req_valid != 2'b00) begin
`ifdef ADD_SLOT_SCHEDULER_RR_EN
                n = (req_valid == 2'b11) ? int'(ptr) : (req_valid[1] ? 1 : 0);
`else
                n = req_valid[0] ? 0 : 1;
`endif
                exp_rdy[n] = 1'b1;
                acc[n] = 1'b1;
                cur = make_op(n);
                cur.acc_win = cyc;
                busy = 1'b1;
                q.push_back(cur);
                ptr = (n == 0);
            end
        end else begin
            ph = cyc - cur.acc_win;
            due = cur.word ? 3 : 2;
            if (ph == 1) begin
                ea = cur.a[7:0];
                eb = cur.b[7:0];
                eci = cur.ci;
            end else if (ph == 2 && cur.word) begin
                ea = cur.a[15:8];
                eb = cur.b[15:8];
                eci = cur.lo_carry;
            end
            if (ph >= due) begin
                exp_rv[cur.owner] = 1'b1;
                if (rsp_ready[cur.owner]) busy = 1'b0;
            end
        end
        check("req_ready0", 32'(req_ready0), 32'(exp_rdy[0]));
        check("req_ready1", 32'(req_ready1), 32'(exp_rdy[1]));
        check("rsp_valid0", 32'(rsp_valid0), 32'(exp_rv[0]));
        check("rsp_valid1", 32'(rsp_valid1), 32'(exp_rv[1]));
        check("add_a", 32'(add_a), 32'(ea));
        check("add_b", 32'(add_b), 32'(eb));
        check("add_ci", 32'(add_ci), 32'(eci));
    end

    // Monitor: compares every presented response with the oldest outstanding expectation.
    always @(negedge clk) begin
        op_t h;
        if (rst_n && (rsp_valid0 || rsp_valid1)) begin
            if (q.size() == 0) begin
                check("rsp_unexpected", 32'({rsp_valid1, rsp_valid0}), 32'd0);
            end else begin
                h = q[0];
                check("rsp_owner", 32'({rsp_valid1, rsp_valid0}), (h.owner != 0) ? 32'd2 : 32'd1);
                check("rsp_sum", 32'(rsp_sum), 32'(h.sum));
                check("rsp_flags", 32'(rsp_flags), 32'(h.flags));
                if (rsp_ready[h.owner]) void'(q.pop_front());
            end
        end
    end

    task automatic issue(input int n, input logic [15:0] a, input logic [15:0] b,
                         input logic w, input logic c);
        bit ok;
        @(posedge clk); #1;
        req_a[n] = a;
        req_b[n] = b;
        req_word[n] = w;
        req_ci[n] = c;
        req_valid[n] = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk); #1;
            ok = acc[n];
        end
        if (!ok) check("issue_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        req_valid[n] = 1'b0;
    endtask

    // Waits (bounded) for requester n's response; lat = negedges after issue returns.
    task automatic expect_rsp(input int n, input logic [15:0] s, input logic [3:0] f,
                              input int lat, input string name);
        bit seen;
        int at;
        seen = 1'b0;
        at = -1;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk); #1;
            if ((n == 0) ? rsp_valid0 : rsp_valid1) begin
                seen = 1'b1;
                at = t;
            end
        end
        check({name, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({name, "_latency"}, 32'(at), 32'(lat));
            check({name, "_sum"}, 32'(rsp_sum), 32'(s));
            check({name, "_flags"}, 32'(rsp_flags), 32'(f));
        end
    endtask

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 7))
            0: return 16'hFFFF;
            1: return 16'h7FFF;
            2: return 16'h8000;
            3: return 16'h0000;
            4: return 16'h00FF;
            default: return 16'($urandom());
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g0, g1;
        bit got;
        req_valid = 2'b00;
        req_word = 2'b00;
        req_ci = 2'b00;
        rsp_ready = 2'b00;
        req_a[0] = 16'h0000; req_a[1] = 16'h0000;
        req_b[0] = 16'h0000; req_b[1] = 16'h0000;
        repeat (3) @(negedge clk);
        check("reset_sum", 32'(rsp_sum), 32'd0);
        check("reset_flags", 32'(rsp_flags), 32'd0);
        #1 rst_n = 1'b1;
        rsp_ready = 2'b11;

        issue(0, 16'h007F, 16'h0001, 1'b0, 1'b0);
        expect_rsp(0, 16'h0080, 4'b1100, 1, "byte_7f");

        issue(1, 16'h00FF, 16'h0001, 1'b1, 1'b0);
        @(negedge clk); #1;
        @(negedge clk); #1;
        check("word_hi_add_ci", 32'(add_ci), 32'd1);
        expect_rsp(1, 16'h0100, 4'b0000, 0, "word_ff");

        issue(0, 16'hFFFF, 16'h0001, 1'b1, 1'b0);
        expect_rsp(0, 16'h0000, 4'b0011, 2, "wrap");

        // Backpressure: requester 0 holds its response while requester 1 waits.
        @(posedge clk); #1;
        rsp_ready = 2'b10;
        issue(0, 16'h0042, 16'h0013, 1'b0, 1'b0);
        req_a[1] = 16'h0005; req_b[1] = 16'h0006; req_word[1] = 1'b0; req_ci[1] = 1'b0;
        req_valid[1] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check("bp_rsp_valid0", 32'(rsp_valid0), 32'd1);
            check("bp_rsp_sum", 32'(rsp_sum), 32'h0055);
            check("bp_req_ready1", 32'(req_ready1), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        check("bp_req1_granted", 32'(req_ready1), 32'd1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        repeat (4) @(negedge clk);

        // Contention: both requesters keep byte ops pending.
        @(posedge clk); #1;
        rsp_ready = 2'b11;
        g0 = 0;
        g1 = 0;
        for (int n = 0; n < 2; n++) begin
            req_a[n] = pick16(); req_b[n] = pick16(); req_word[n] = 1'b0; req_ci[n] = 1'b0;
        end
        req_valid = 2'b11;
        for (int k = 0; k < 8; k++) begin
            got = 1'b0;
            for (int t = 0; t < 20 && !got; t++) begin
                @(negedge clk); #1;
                if (req_ready0) begin g0++; got = 1'b1; end
                if (req_ready1) begin g1++; got = 1'b1; end
            end
            if (!got) check("contend_timeout", 32'd0, 32'd1);
            @(posedge clk); #1;
            for (int n = 0; n < 2; n++) begin
                if (acc[n]) begin req_a[n] = pick16(); req_b[n] = pick16(); end
            end
        end
        req_valid = 2'b00;
`ifdef ADD_SLOT_SCHEDULER_RR_EN
        check("contend_grants0", 32'(g0), 32'd4);
        check("contend_grants1", 32'(g1), 32'd4);
`else
        check("contend_grants0", 32'(g0), 32'd8);
        check("contend_grants1", 32'(g1), 32'd0);
`endif
        repeat (4) @(negedge clk);

        // Reset while the high byte pass is on the adder.
        issue(0, 16'h1357, 16'h2468, 1'b1, 1'b0);
        @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rst_add_a", 32'(add_a), 32'd0);
        check("rst_add_b", 32'(add_b), 32'd0);
        check("rst_add_ci", 32'(add_ci), 32'd0);
        check("rst_rsp_valid0", 32'(rsp_valid0), 32'd0);
        check("rst_rsp_sum", 32'(rsp_sum), 32'd0);
        check("rst_rsp_flags", 32'(rsp_flags), 32'd0);
        @(negedge clk);
        @(negedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        issue(1, 16'h0010, 16'h0020, 1'b0, 1'b1);
        expect_rsp(1, 16'h0031, 4'b0000, 1, "after_reset");

        // Randomized traffic with withdrawals and response backpressure.
        for (int c = 0; c < 2500; c++) begin
            @(posedge clk); #1;
            for (int n = 0; n < 2; n++) begin
                if (acc[n] || !req_valid[n]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        req_valid[n] = 1'b1;
                        req_a[n] = pick16();
                        req_b[n] = pick16();
                        req_word[n] = 1'($urandom_range(0, 1));
                        req_ci[n] = 1'($urandom_range(0, 1));
                    end else begin
                        req_valid[n] = 1'b0;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[n] = 1'b0;
                end
                rsp_ready[n] = ($urandom_range(0, 3) != 0);
            end
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        repeat (10) @(negedge clk);
        check("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/add_slot_scheduler.md
# add_slot_scheduler

Sequencer and arbiter that shares one combinational 8-bit adder slice (carry-in/carry-out) between two requesters in the 8088 ALU. It accepts byte or word additions through valid/ready handshakes and runs words as two back-to-back byte passes, low byte first, with the carry chained between them. It returns an 8- or 16-bit sum with carry/zero/sign/overflow flags to the requester that issued the operation. It sits between the ALU front-end ports and the shared adder instance.

## Interface
- No parameters; widths fixed (8-bit slice, 16-bit operand).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid0 / req_valid1  in  1  requester n has an operation pending.
- req_ready0 / req_ready1  out  1  requester n's operation is accepted this cycle.
- req_a0, req_b0 / req_a1, req_b1  in  16  operands; byte ops use [7:0] only.
- req_word0 / req_word1  in  1  1 = 16-bit add, 0 = 8-bit add.
- req_ci0 / req_ci1  in  1  carry-in for the lowest byte.
- rsp_valid0 / rsp_valid1  out  1  result for requester n is held on rsp_*.
- rsp_ready0 / rsp_ready1  in  1  requester n consumes its result.
- rsp_sum  out  16  result; [15:8] = 0 for byte ops.
- rsp_flags  out  4  {OF, SF, ZF, CF} of the completed operation.
- add_a, add_b  out  8  operands driven to the shared adder.
- add_ci  out  1  carry-in driven to the shared adder.
- add_r  in  8  adder sum (combinational from add_a/add_b/add_ci).
- add_co  in  1  adder carry-out.

## Operation
- FSM states: IDLE, LO, HI, DONE.
- IDLE:
  - Arbitrate among asserted req_valid; pulse req_ready of the winner only for one cycle.
  - Latch the winner's a, b, word and ci, plus an owner bit.
  - Go to LO.
  - No request: stay in IDLE.
- LO:
  - Drive add_a = a[7:0], add_b = b[7:0], add_ci = ci.
  - Capture add_r into sum[7:0] and add_co into an internal carry.
  - Go to HI if word, else DONE.
- HI:
  - Drive a[15:8], b[15:8], add_ci = captured carry.
  - Capture add_r into sum[15:8] and add_co.
  - Go to DONE.
- add_a/add_b/add_ci are 0 in IDLE and DONE.
- DONE:
  - Assert rsp_valid of the owner only.
  - rsp_sum and rsp_flags stay stable until the owner's rsp_ready is high at a clock edge; then go to IDLE.
  - The other requester's rsp_ready is ignored.
- Flags:
  - CF = carry-out of the last pass.
  - ZF = (result of the operation width == 0).
  - SF = MSB of the operation width (bit 7 or bit 15).
  - OF = (a_msb == b_msb) && (sum_msb != a_msb), taken at the operation width.
- Arbitration is fixed priority by default: requester 0 wins ties. See Configuration.
- One operation is in flight at a time. A request arriving while the FSM is not in IDLE waits with req_valid held; the requester must keep its operands stable until req_ready.

## Timing
- Reset (asynchronous assert, synchronous release):
  - FSM = IDLE.
  - All outputs 0: req_ready*, rsp_valid*, rsp_sum, rsp_flags, add_*.
  - Owner and round-robin pointer = 0.
- Reset during LO/HI/DONE aborts the operation: no response, and the latched request is lost.
- Latency, with acceptance (req_ready high) at edge k:
  - Byte op: rsp_valid rises after edge k+2.
  - Word op: rsp_valid rises after edge k+3.
- If rsp_ready is already high when rsp_valid rises, rsp_valid is high exactly one cycle.
- Minimum spacing between acceptances: 3 cycles (byte) or 4 cycles (word).
- A requester whose req_valid drops before req_ready gets no operation; no error is flagged.
- Carry wrap: word 0xFFFF + 0x0001 -> sum 0x0000, CF = 1, ZF = 1.

## Configuration
- ADD_SLOT_SCHEDULER_RR_EN defined:
  - Round-robin arbitration. On a tie, the requester not granted last wins.
  - The pointer updates only on a grant.
- Undefined:
  - Fixed priority, requester 0 always wins ties.
  - The pointer register is not built.

## Test plan
- Byte op, req0 a=0x7F, b=0x01, ci=0 -> rsp_valid0 two edges after acceptance; sum=0x0080, flags OF=1, SF=1, ZF=0, CF=0.
- Word op, req1 a=0x00FF, b=0x0001, ci=0 -> add_ci=1 in HI; sum=0x0100, CF=0, ZF=0; rsp_valid1 three edges after acceptance.
- Both requesters valid continuously with byte ops and rsp_ready held high:
  - Without RR_EN: requester 0 is served every grant while it stays valid.
  - With RR_EN: grants alternate 0,1,0,1.
- Backpressure: rsp_ready0 = 0 for 5 cycles in DONE -> rsp_valid0 and rsp_sum stay stable, req1 not granted; rsp_ready0 = 1 -> IDLE next cycle, then req1 granted.
- Wrap: word 0xFFFF + 0x0001, ci=0 -> sum 0x0000, CF=1, ZF=1, OF=0.
- rst_n pulsed low during HI -> outputs 0 immediately, no rsp_valid afterwards, next request served normally.
